// File: rtl/perm_engine.sv
// Runtime-programmable bit-permutation engine with a one-stage valid/ready output register.
// A sequential checker re-verifies that the table is a bijection after every table write.
module perm_engine #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDXW-1:0]  cfg_idx,
    input  logic [IDXW-1:0]  cfg_src,
    output logic             cfg_ack,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             table_ok
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [IDXW:0]   WIDTH_L = (IDXW+1)'(WIDTH);
    localparam logic [IDXW-1:0] K_LAST  = IDXW'(WIDTH - 1);

    state_t            state_reg, state_next;
    logic [IDXW-1:0]   map_reg [WIDTH];
    logic [IDXW-1:0]   k_reg;
    logic [WIDTH-1:0]  seen_reg;
    logic              dup_reg;
    logic              table_ok_reg;
    logic              cfg_ack_reg, cfg_err_reg;
    logic              out_valid_reg, out_err_reg;
    logic [WIDTH-1:0]  out_data_reg;

    logic              idle, beat_fire, cfg_fire, cfg_in_range, cfg_good;
    logic              scan_last, dup_hit, use_inv;
    logic [IDXW-1:0]   cur_src;
    logic [WIDTH-1:0]  fwd_data, inv_data;

    assign idle         = (state_reg == IDLE);
    assign in_ready     = idle && (!out_valid_reg || out_ready);
    assign beat_fire    = in_valid && in_ready;
    assign cfg_fire     = cfg_we && idle && !out_valid_reg && !beat_fire;
    assign cfg_in_range = ({1'b0, cfg_idx} < WIDTH_L) && ({1'b0, cfg_src} < WIDTH_L);
    assign cfg_good     = cfg_fire && cfg_in_range;
    assign scan_last    = (state_reg == SCAN) && (k_reg == K_LAST);
    assign cur_src      = map_reg[k_reg];
    assign dup_hit      = seen_reg[cur_src];
    assign use_inv      = in_inv && table_ok_reg;

    assign cfg_ack   = cfg_ack_reg;
    assign cfg_err   = cfg_err_reg;
    assign table_ok  = table_ok_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_err   = out_err_reg;

    // Table entries reset to identity; each entry owns its own write enable.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_map
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    map_reg[gi] <= IDXW'(gi);
                end else if (cfg_good && (cfg_idx == IDXW'(gi))) begin
                    map_reg[gi] <= cfg_src;
                end
            end
            assign fwd_data[gi] = in_data[map_reg[gi]];
        end
    endgenerate

    // Scatter form of the inverse; OR-merge keeps it well defined even for a non-bijective table.
    always_comb begin
        inv_data = '0;
        for (int i = 0; i < WIDTH; i++) begin
            inv_data[map_reg[i]] = inv_data[map_reg[i]] | in_data[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cfg_good) state_next = SCAN;
            SCAN:    if (scan_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_err_reg   <= 1'b0;
        end else if (beat_fire) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= use_inv ? inv_data : fwd_data;
            out_err_reg   <= in_inv && !table_ok_reg;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ack_reg  <= 1'b0;
            cfg_err_reg  <= 1'b0;
            table_ok_reg <= 1'b1;
            k_reg        <= '0;
            seen_reg     <= '0;
            dup_reg      <= 1'b0;
        end else begin
            cfg_ack_reg <= cfg_good;
            cfg_err_reg <= cfg_fire && !cfg_in_range;
            if (cfg_good) begin
                table_ok_reg <= 1'b0;
                k_reg        <= '0;
                seen_reg     <= '0;
                dup_reg      <= 1'b0;
            end else if (state_reg == SCAN) begin
                seen_reg[cur_src] <= 1'b1;
                if (dup_hit) dup_reg <= 1'b1;
                k_reg <= k_reg + 1'b1;
                // The final entry's own duplicate hit must count too.
                if (scan_last) table_ok_reg <= !(dup_reg || dup_hit);
            end
        end
    end

endmodule

// File: tb/tb_perm_engine.sv
// Self-checking bench for perm_engine: vector table, randomized beats against a
// behavioural permutation model, and hand-written handshake corner cases.
module tb_perm_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [4:0]  cfg_idx, cfg_src;
    logic        cfg_ack, cfg_err;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        in_inv;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        out_err, table_ok;

    perm_engine #(.WIDTH(32), .IDXW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_src(cfg_src),
        .cfg_ack(cfg_ack), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .table_ok(table_ok)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;
    int map_m [32];
    int des_p [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                       2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

    typedef struct {
        logic [31:0] data;
        logic        inv;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic logic [31:0] model_fwd(input logic [31:0] d);
        logic [31:0] r = '0;
        for (int i = 0; i < 32; i++) r[i] = d[map_m[i]];
        return r;
    endfunction

    function automatic logic [31:0] model_inv(input logic [31:0] d);
        logic [31:0] r = '0;
        for (int i = 0; i < 32; i++) r[map_m[i]] = d[i];
        return r;
    endfunction

    function automatic logic model_ok();
        int cnt [32];
        for (int i = 0; i < 32; i++) cnt[i] = 0;
        for (int i = 0; i < 32; i++) cnt[map_m[i]]++;
        for (int i = 0; i < 32; i++) if (cnt[i] != 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_identity();
        for (int i = 0; i < 32; i++) map_m[i] = i;
    endfunction

    // Expected result of a beat given the model table and its verified state.
    function automatic logic [31:0] model_beat(input logic [31:0] d, input logic inv);
        if (inv && model_ok()) return model_inv(d);
        return model_fwd(d);
    endfunction

    task automatic do_beat(input logic [31:0] d, input logic inv,
                           output logic [31:0] od, output logic oe);
        int n = 0;
        od = '0;
        oe = 1'b0;
        in_data  = d;
        in_inv   = inv;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            chk("beat_accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("beat_out_valid", 32'(out_valid), 32'd1);
        od = out_data;
        oe = out_err;
    endtask

    task automatic wait_scan_done();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("scan_done_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic cfg_write(input int idx, input int src);
        int n = 0;
        cfg_idx = 5'(idx);
        cfg_src = 5'(src);
        cfg_we  = 1'b1;
        do begin
            @(posedge clk); #1; n++;
        end while (!cfg_ack && n < 400);
        cfg_we = 1'b0;
        if (!cfg_ack) chk("cfg_ack_timeout", 32'(cfg_ack), 32'd1);
        map_m[idx] = src;
        wait_scan_done();
    endtask

    logic [31:0] od, y, a, b, c;
    logic        oe, inv_r;
    int          n, perm [32];

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_src = '0;
        in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b1;
        model_identity();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);
        chk("rst_cfg_ack",   32'(cfg_ack),   32'd0);
        chk("rst_cfg_err",   32'(cfg_err),   32'd0);
        chk("rst_table_ok",  32'(table_ok),  32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Identity after reset
        do_beat(32'hDEADBEEF, 1'b0, od, oe);
        chk("ident_data", od, 32'hDEADBEEF);
        chk("ident_err",  32'(oe), 32'd0);
        chk("ident_table_ok", 32'(table_ok), 32'd1);
        @(posedge clk); #1;

        // Duplicate entry map[0]=1
        cfg_idx = 5'd0; cfg_src = 5'd1; cfg_we = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!cfg_ack && n < 100);
        cfg_we = 1'b0;
        map_m[0] = 1;
        chk("dup_ack", 32'(cfg_ack), 32'd1);
        chk("dup_table_ok_scan", 32'(table_ok), 32'd0);
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
            if (n == 1) chk("dup_ack_pulse", 32'(cfg_ack), 32'd0);
        end
        chk("dup_scan_cycles", 32'(n), 32'd32);
        chk("dup_table_ok_after", 32'(table_ok), 32'(model_ok()));
        do_beat(32'h2, 1'b1, od, oe);
        chk("dup_inv_data", od, 32'h3);
        chk("dup_inv_err",  32'(oe), 32'd1);
        cfg_write(1, 0);
        chk("dup_fixed_table_ok", 32'(table_ok), 32'd1);

        // DES P table
        for (int i = 0; i < 32; i++) cfg_write(i, 32 - des_p[31 - i]);
        chk("des_table_ok", 32'(table_ok), 32'd1);
        vecs[0] = '{32'h00000001, 1'b0, 32'h00000800, 1'b0};
        vecs[1] = '{32'h00000080, 1'b0, 32'h00000001, 1'b0};
        vecs[2] = '{32'h00000800, 1'b1, 32'h00000001, 1'b0};
        vecs[3] = '{32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0};
        vecs[4] = '{32'h00000001, 1'b1, 32'h00000080, 1'b0};
        for (int v = 0; v < 5; v++) begin
            do_beat(vecs[v].data, vecs[v].inv, od, oe);
            chk($sformatf("vec%0d_data", v), od, vecs[v].exp_data);
            chk($sformatf("vec%0d_err", v),  32'(oe), 32'(vecs[v].exp_err));
        end

        for (int r = 0; r < 16; r++) begin
            a = $urandom; inv_r = 1'($urandom_range(1, 0));
            do_beat(a, inv_r, od, oe);
            chk($sformatf("des_rand%0d", r), od, model_beat(a, inv_r));
        end
        for (int r = 0; r < 6; r++) begin
            a = $urandom;
            do_beat(a, 1'b0, y, oe);
            do_beat(y, 1'b1, od, oe);
            chk($sformatf("roundtrip%0d", r), od, a);
        end

        // Backpressure
        @(posedge clk); #1;
        a = $urandom; b = $urandom;
        out_ready = 1'b0; in_inv = 1'b0; in_data = a; in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = b;
        chk("bp_a_captured", out_data, model_fwd(a));
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_a_held", out_data, model_fwd(a));
        chk("bp_valid_held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_b_loaded", out_data, model_fwd(b));
        chk("bp_b_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Collision of config write and data beat
        c = $urandom;
        cfg_idx = 5'd5; cfg_src = 5'(map_m[5]); cfg_we = 1'b1;
        in_data = c; in_inv = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("coll_beat", out_data, model_fwd(c));
        chk("coll_no_ack", 32'(cfg_ack), 32'd0);
        n = 1;
        while (!cfg_ack && n < 100) begin @(posedge clk); #1; n++; end
        cfg_we = 1'b0;
        chk("coll_ack_edge", 32'(n), 32'd3);
        chk("coll_ack_outv", 32'(out_valid), 32'd0);
        wait_scan_done();
        chk("coll_table_ok", 32'(table_ok), 32'd1);

        // Random permutation table
        for (int i = 0; i < 32; i++) perm[i] = i;
        for (int i = 31; i > 0; i--) begin
            n = $urandom_range(i, 0);
            {perm[i], perm[n]} = {perm[n], perm[i]};
        end
        for (int i = 0; i < 32; i++) cfg_write(i, perm[i]);
        chk("rperm_table_ok", 32'(table_ok), 32'd1);
        for (int r = 0; r < 12; r++) begin
            a = $urandom; inv_r = 1'($urandom_range(1, 0));
            do_beat(a, inv_r, od, oe);
            chk($sformatf("rperm_rand%0d", r), od, model_beat(a, inv_r));
        end

        // Reset in the middle of a scan
        @(posedge clk); #1;
        cfg_idx = 5'd3; cfg_src = 5'(map_m[3]); cfg_we = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!cfg_ack && n < 100);
        cfg_we = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_table_ok", 32'(table_ok), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_identity();
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        a = 32'h12345678;
        do_beat(a, 1'b0, od, oe);
        chk("mid_rst_ident", od, model_fwd(a));
        do_beat(32'h80000001, 1'b1, od, oe);
        chk("mid_rst_inv", od, 32'h80000001);
        chk("mid_rst_inv_err", 32'(oe), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
